multiport_register_file: RTL and testbench
==========================================

Name: multiport_register_file

Overview:
- Parametrised successor to the single-core register file.
- Provides N_RD combinational read ports and N_WR synchronous write ports over NREGS words.
- Register 0 is hardwired to zero.
- Adds a per-register pending-write scoreboard so the pipelined / dual-issue datapath can detect RAW hazards without external tracking.
- Sits between decode (reads, issue marking) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 32, word width in bits
- NREGS, 32, number of architectural registers (power of two, >= 4)
- N_RD, 2, number of read ports
- N_WR, 2, number of write ports
- SEL_W, $clog2(NREGS), register select width (derived, not overridden)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous active-high reset
- rsel  in  N_RD x SEL_W  read selects
- rdat  out  N_RD x DATA_W  read data
- rbusy  out  N_RD  1 = the selected register has an outstanding pending write
- wen  in  N_WR  write enables
- wsel  in  N_WR x SEL_W  write selects
- wdat  in  N_WR x DATA_W  write data
- iss_en  in  1  issue: mark iss_sel as pending
- iss_sel  in  SEL_W  destination register being issued
- pend_cnt  out  SEL_W+1  number of registers currently pending
- sb_full  out  1  pend_cnt == NREGS-1 (every writable register pending)

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values:
  - all register words = 0
  - all scoreboard bits = 0
  - pend_cnt = 0
  - sb_full = 0
  - rdat = 0 and rbusy = 0, since they follow combinationally from the cleared state
- Reset mid-operation: state clears immediately on RST assertion, independent of CLK. Writes and issues presented in the cycle RST is released are ignored. Normal operation resumes on the first rising edge with RST low.
- Reads:
  - Purely combinational: rdat[i] = reg[rsel[i]].
  - rsel[i] == 0 gives 0 and rbusy[i] = 0.
- Writes:
  - On a rising edge, each port with wen[j] = 1 and wsel[j] != 0 writes wdat[j].
  - A write to register 0 is discarded.
  - Same-cycle collision on one wsel: the highest-indexed port wins. Lower ports to that register are dropped entirely.
- Scoreboard, per register r (r != 0), on a rising edge:
  - set = iss_en && iss_sel == r
  - clr = any wen[j] && wsel[j] == r
  - set && clr: bit ends 1, because the new producer supersedes the old one
  - clr only: bit ends 0
  - set only: bit ends 1
  - Issuing a register that is already pending leaves it 1 and does not increment pend_cnt.
  - A write to a non-pending register is legal. Data is updated and the scoreboard is unchanged.
  - iss_sel == 0 is ignored.
- pend_cnt:
  - Registered and maintained incrementally: +1 on a 0->1 transition, -1 for each 1->0 transition in the cycle. A multi-port clear can decrement by up to N_WR.
  - Never wraps. The maximum reachable value is NREGS-1, which is when sb_full asserts.
- Latency: a write is visible on rdat one cycle after the edge, unless RF_BYPASS_EN is defined.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. rdat[i] = wdat[j] when wen[j] && wsel[j] == rsel[i] != 0, with the highest j winning. Otherwise the stored word.
  - rbusy[i] is forced to 0 in that same cycle, because the value is available.
- Undefined:
  - Reads return stored contents only.
  - rbusy reflects the registered scoreboard bit.

Decomposition:
- Shared package (cpu_types_pkg):
  - word_t (DATA_W-bit)
  - regbits_t (SEL_W-bit select)
  - constant ZERO_REG = 0
- One sub-module, rf_scoreboard:
  - Owns the pending bits, set/clr priority and pend_cnt / sb_full.
  - Inputs: iss_en, iss_sel, wen, wsel.
  - Outputs: the pending vector, pend_cnt and sb_full.
- The top module holds the data array, the write priority logic, the read muxes and the optional bypass.

Test Plan:
- Reset and zero register: assert RST mid-run after filling r5 = 0xDEADBEEF -> rdat reads 0 immediately and pend_cnt = 0. Then write r0 = 0xFFFFFFFF -> rsel = 0 reads 0 and rbusy = 0.
- Write collision: wen = 2'b11, wsel = {7, 7}, wdat = {0x22222222, 0x11111111} -> next cycle r7 = 0x22222222 (port 1 wins).
- Scoreboard hazard: iss r9; next cycle rsel0 = 9 -> rbusy0 = 1 and pend_cnt = 1. Write r9 = 0x1234 -> after the edge rbusy0 = 0, rdat0 = 0x1234, pend_cnt = 0.
- Set/clear collision: r4 pending; same cycle iss_sel = 4 and wen on r4 -> r4 still pending, pend_cnt unchanged, data updated.
- Full scoreboard: issue r1..r31 over 31 cycles -> pend_cnt = 31 and sb_full = 1. A dual write clearing r3 and r8 -> pend_cnt = 29 and sb_full = 0.
- Bypass (RF_BYPASS_EN): r12 pending, wen on r12 = 0xCAFEF00D with rsel1 = 12 in the same cycle -> rdat1 = 0xCAFEF00D and rbusy1 = 0 combinationally. Without the macro, rdat1 shows the old value and rbusy1 = 1 that cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and defaults for the multiport register file slice.
package cpu_types_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_NREGS  = 32;
    localparam int unsigned DEF_SEL_W  = $clog2(DEF_NREGS);

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_SEL_W-1:0]  regbits_t;

    localparam regbits_t ZERO_REG = '0;

endpackage

// File: rtl/multiport_register_file_if.sv
// Decode/writeback bus of the multiport register file: read ports, write ports, issue and scoreboard status.
interface multiport_register_file_if
    import cpu_types_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned NREGS  = DEF_NREGS,
    parameter  int unsigned N_RD   = 2,
    parameter  int unsigned N_WR   = 2,
    localparam int unsigned SEL_W  = $clog2(NREGS)
) ();

    logic [N_RD-1:0][SEL_W-1:0]  rsel;
    logic [N_RD-1:0][DATA_W-1:0] rdat;
    logic [N_RD-1:0]             rbusy;
    logic [N_WR-1:0]             wen;
    logic [N_WR-1:0][SEL_W-1:0]  wsel;
    logic [N_WR-1:0][DATA_W-1:0] wdat;
    logic                        iss_en;
    logic [SEL_W-1:0]            iss_sel;
    logic [SEL_W:0]              pend_cnt;
    logic                        sb_full;

    modport master (
        output rsel, wen, wsel, wdat, iss_en, iss_sel,
        input  rdat, rbusy, pend_cnt, sb_full
    );

    modport slave (
        input  rsel, wen, wsel, wdat, iss_en, iss_sel,
        output rdat, rbusy, pend_cnt, sb_full
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with incremental pending count and full flag.
module rf_scoreboard
    import cpu_types_pkg::*;
#(
    parameter  int unsigned NREGS = DEF_NREGS,
    parameter  int unsigned N_WR  = 2,
    localparam int unsigned SEL_W = $clog2(NREGS)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       iss_en,
    input  logic [SEL_W-1:0]           iss_sel,
    input  logic [N_WR-1:0]            wen,
    input  logic [N_WR-1:0][SEL_W-1:0] wsel,
    output logic [NREGS-1:0]           pend,
    output logic [SEL_W:0]             pend_cnt,
    output logic                       sb_full
);

    logic [NREGS-1:0] r_pend;
    logic [SEL_W:0]   r_cnt;
    logic             r_full;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_next;
    logic [SEL_W:0]   w_cnt_next;

    // A new issue supersedes a same-cycle writeback of the old producer.
    always_comb begin
        w_set      = '0;
        w_clr      = '0;
        w_next     = '0;
        w_cnt_next = r_cnt;
        for (int unsigned r = 1; r < NREGS; r++) begin
            w_set[r] = iss_en && (iss_sel == SEL_W'(r));
            for (int unsigned j = 0; j < N_WR; j++) begin
                if (wen[j] && (wsel[j] == SEL_W'(r))) begin
                    w_clr[r] = 1'b1;
                end
            end
            w_next[r] = w_set[r] | (r_pend[r] & ~w_clr[r]);
            if (!r_pend[r] && w_next[r]) begin
                w_cnt_next = w_cnt_next + (SEL_W+1)'(1);
            end else if (r_pend[r] && !w_next[r]) begin
                w_cnt_next = w_cnt_next - (SEL_W+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            r_pend <= w_next;
            r_cnt  <= w_cnt_next;
            r_full <= (w_cnt_next == (SEL_W+1)'(NREGS-1));
        end
    end

    assign pend     = r_pend;
    assign pend_cnt = r_cnt;
    assign sb_full  = r_full;

endmodule

// File: rtl/multiport_register_file.sv
// N_RD-read / N_WR-write register file with r0 hardwired to zero and a RAW scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module multiport_register_file
    import cpu_types_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned NREGS  = DEF_NREGS,
    parameter  int unsigned N_RD   = 2,
    parameter  int unsigned N_WR   = 2,
    localparam int unsigned SEL_W  = $clog2(NREGS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    multiport_register_file_if.slave bus
);

    logic [DATA_W-1:0]           r_regs [NREGS];
    logic [NREGS-1:0]            w_pend;
    logic [N_RD-1:0][DATA_W-1:0] w_rdat;
    logic [N_RD-1:0]             w_rbusy;

    rf_scoreboard #(
        .NREGS (NREGS),
        .N_WR  (N_WR)
    ) u_sb (
        .CLK      (CLK),
        .RST      (RST),
        .iss_en   (bus.iss_en),
        .iss_sel  (bus.iss_sel),
        .wen      (bus.wen),
        .wsel     (bus.wsel),
        .pend     (w_pend),
        .pend_cnt (bus.pend_cnt),
        .sb_full  (bus.sb_full)
    );

    // Ports are scanned in ascending order so the highest-indexed writer lands last.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                for (int unsigned j = 0; j < N_WR; j++) begin
                    if (bus.wen[j] && (bus.wsel[j] == SEL_W'(r))) begin
                        r_regs[r] <= bus.wdat[j];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdat  = '0;
        w_rbusy = '0;
        for (int unsigned i = 0; i < N_RD; i++) begin
            if (bus.rsel[i] != SEL_W'(ZERO_REG)) begin
                w_rdat[i]  = r_regs[bus.rsel[i]];
                w_rbusy[i] = w_pend[bus.rsel[i]];
`ifdef RF_BYPASS_EN
                for (int unsigned j = 0; j < N_WR; j++) begin
                    if (bus.wen[j] && (bus.wsel[j] == bus.rsel[i])) begin
                        w_rdat[i]  = bus.wdat[j];
                        w_rbusy[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.rdat  = w_rdat;
    assign bus.rbusy = w_rbusy;

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: directed stimulus queues expectations, a negedge monitor checks them.
module tb_multiport_register_file;
    import cpu_types_pkg::*;

    localparam int unsigned SEL_RDAT0  = 0;
    localparam int unsigned SEL_RDAT1  = 1;
    localparam int unsigned SEL_RBUSY0 = 2;
    localparam int unsigned SEL_RBUSY1 = 3;
    localparam int unsigned SEL_PCNT   = 4;
    localparam int unsigned SEL_FULL   = 5;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [31:0] exp;
    } chk_t;

    logic CLK;
    logic RST;
    chk_t q[$];
    int   n_vec;
    int   n_bad;

    multiport_register_file_if #(
        .DATA_W (32),
        .NREGS  (32),
        .N_RD   (2),
        .N_WR   (2)
    ) bus ();

    multiport_register_file #(
        .DATA_W (32),
        .NREGS  (32),
        .N_RD   (2),
        .N_WR   (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] actual(input int unsigned sel);
        case (sel)
            SEL_RDAT0:  return bus.rdat[0];
            SEL_RDAT1:  return bus.rdat[1];
            SEL_RBUSY0: return 32'(bus.rbusy[0]);
            SEL_RBUSY1: return 32'(bus.rbusy[1]);
            SEL_PCNT:   return 32'(bus.pend_cnt);
            default:    return 32'(bus.sb_full);
        endcase
    endfunction

    // Monitor: drains every queued expectation against the settled outputs.
    initial begin
        n_vec = 0;
        n_bad = 0;
        forever begin
            @(negedge CLK);
            while (q.size() > 0) begin
                chk_t c;
                logic [31:0] a;
                c = q.pop_front();
                a = actual(c.sel);
                n_vec++;
                if (a !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, a, c.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int unsigned sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.wen    = '0;
        bus.iss_en = 1'b0;
    endtask

    initial begin
        RST         = 1'b1;
        bus.rsel[0] = 5'd5;
        bus.rsel[1] = 5'd0;
        bus.wen     = '0;
        bus.wsel    = '0;
        bus.wdat    = '0;
        bus.iss_en  = 1'b0;
        bus.iss_sel = '0;
        expect_val("reset_rdat0", SEL_RDAT0, 32'h0);
        expect_val("reset_rbusy0", SEL_RBUSY0, 32'h0);
        expect_val("reset_pend_cnt", SEL_PCNT, 32'h0);
        expect_val("reset_sb_full", SEL_FULL, 32'h0);
        tick();
        RST = 1'b0;
        tick();

        // fill r5, mark r6 pending, then reset asynchronously mid-run
        bus.wen[0]  = 1'b1;
        bus.wsel[0] = 5'd5;
        bus.wdat[0] = 32'hDEADBEEF;
        bus.iss_en  = 1'b1;
        bus.iss_sel = 5'd6;
        tick();
        idle();
        expect_val("fill_r5", SEL_RDAT0, 32'hDEADBEEF);
        expect_val("fill_pend_cnt", SEL_PCNT, 32'd1);
        tick();
        RST = 1'b1;
        expect_val("midrst_rdat0", SEL_RDAT0, 32'h0);
        expect_val("midrst_pend_cnt", SEL_PCNT, 32'h0);
        tick();
        RST = 1'b0;
        tick();

        // write to r0 and issue r0 are both discarded
        bus.wen[0]  = 1'b1;
        bus.wsel[0] = 5'd0;
        bus.wdat[0] = 32'hFFFFFFFF;
        bus.iss_en  = 1'b1;
        bus.iss_sel = 5'd0;
        tick();
        idle();
        bus.rsel[0] = 5'd0;
        expect_val("r0_rdat0", SEL_RDAT0, 32'h0);
        expect_val("r0_rbusy0", SEL_RBUSY0, 32'h0);
        expect_val("r0_pend_cnt", SEL_PCNT, 32'h0);

        // same-cycle collision on r7: port 1 wins
        bus.wen     = 2'b11;
        bus.wsel[0] = 5'd7;
        bus.wsel[1] = 5'd7;
        bus.wdat[0] = 32'h11111111;
        bus.wdat[1] = 32'h22222222;
        tick();
        idle();
        bus.rsel[1] = 5'd7;
        expect_val("collision_r7", SEL_RDAT1, 32'h22222222);
        expect_val("collision_pend_cnt", SEL_PCNT, 32'h0);

        // RAW hazard on r9
        bus.iss_en  = 1'b1;
        bus.iss_sel = 5'd9;
        tick();
        idle();
        bus.rsel[0] = 5'd9;
        expect_val("hazard_rbusy0", SEL_RBUSY0, 32'd1);
        expect_val("hazard_pend_cnt", SEL_PCNT, 32'd1);
        tick();
        bus.wen[0]  = 1'b1;
        bus.wsel[0] = 5'd9;
        bus.wdat[0] = 32'h00001234;
        tick();
        idle();
        expect_val("hazard_clr_rbusy0", SEL_RBUSY0, 32'd0);
        expect_val("hazard_clr_rdat0", SEL_RDAT0, 32'h00001234);
        expect_val("hazard_clr_pend_cnt", SEL_PCNT, 32'd0);

        // set and clear of r4 in the same cycle
        bus.iss_en  = 1'b1;
        bus.iss_sel = 5'd4;
        tick();
        bus.wen[0]  = 1'b1;
        bus.wsel[0] = 5'd4;
        bus.wdat[0] = 32'h0000ABCD;
        tick();
        idle();
        bus.rsel[0] = 5'd4;
        expect_val("setclr_rbusy0", SEL_RBUSY0, 32'd1);
        expect_val("setclr_pend_cnt", SEL_PCNT, 32'd1);
        expect_val("setclr_rdat0", SEL_RDAT0, 32'h0000ABCD);
        tick();
        bus.wen[0]  = 1'b1;
        bus.wsel[0] = 5'd4;
        bus.wdat[0] = 32'h00004444;
        tick();
        idle();
        expect_val("r4_retire_pend_cnt", SEL_PCNT, 32'd0);

        // same-cycle read of r12 while it is being written
        bus.iss_en  = 1'b1;
        bus.iss_sel = 5'd12;
        tick();
        idle();
        bus.wen[1]  = 1'b1;
        bus.wsel[1] = 5'd12;
        bus.wdat[1] = 32'hCAFEF00D;
        bus.rsel[1] = 5'd12;
`ifdef RF_BYPASS_EN
        expect_val("bypass_rdat1", SEL_RDAT1, 32'hCAFEF00D);
        expect_val("bypass_rbusy1", SEL_RBUSY1, 32'd0);
`else
        expect_val("nobypass_rdat1", SEL_RDAT1, 32'h0);
        expect_val("nobypass_rbusy1", SEL_RBUSY1, 32'd1);
`endif
        tick();
        idle();
        expect_val("r12_after_rdat1", SEL_RDAT1, 32'hCAFEF00D);
        expect_val("r12_after_rbusy1", SEL_RBUSY1, 32'd0);
        expect_val("r12_after_pend_cnt", SEL_PCNT, 32'd0);

        // fill the scoreboard
        for (int unsigned r = 1; r < 32; r++) begin
            bus.iss_en  = 1'b1;
            bus.iss_sel = 5'(r);
            tick();
            if (r == 30) begin
                expect_val("fill30_pend_cnt", SEL_PCNT, 32'd30);
                expect_val("fill30_sb_full", SEL_FULL, 32'd0);
            end
        end
        idle();
        expect_val("full_pend_cnt", SEL_PCNT, 32'd31);
        expect_val("full_sb_full", SEL_FULL, 32'd1);
        bus.iss_en  = 1'b1;
        bus.iss_sel = 5'd5;
        tick();
        idle();
        expect_val("reissue_pend_cnt", SEL_PCNT, 32'd31);
        bus.wen     = 2'b11;
        bus.wsel[0] = 5'd3;
        bus.wsel[1] = 5'd8;
        bus.wdat[0] = 32'h33333333;
        bus.wdat[1] = 32'h88888888;
        tick();
        idle();
        bus.rsel[0] = 5'd3;
        bus.rsel[1] = 5'd31;
        expect_val("dualclr_pend_cnt", SEL_PCNT, 32'd29);
        expect_val("dualclr_sb_full", SEL_FULL, 32'd0);
        expect_val("dualclr_rbusy0", SEL_RBUSY0, 32'd0);
        expect_val("dualclr_rbusy1", SEL_RBUSY1, 32'd1);
        expect_val("dualclr_rdat0", SEL_RDAT0, 32'h33333333);

        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            @(posedge CLK);
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
